seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the status display. It is the successor to the fixed 8-digit state display path. It accepts a full display image (hex nibbles, per-digit enable, decimal point and blink flags) through a valid/ready handshake. It double-buffers the image so updates commit only at frame boundaries, scans the digits, and adds global PWM brightness and per-digit blinking.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyphs and
// the inactive cathode level used by the display paths.
package seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_W  = 8;

  // Cathodes are active-low, so a released line sits high.
  localparam logic CAT_OFF = 1'b1;

  // Glyphs in g..a order; "b" and "d" are the lowercase forms.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-high segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nib,
  input  logic             dp,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c              = '0;
    seg_c[SEG_G:SEG_A] = HEX_GLYPH[nib];
    seg_c[SEG_DP]      = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a double-buffered display image,
// frame-aligned commits, global PWM brightness and per-digit blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned PWM_BITS     = 3,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_en,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blink,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     cat,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_start
);

  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0][3:0] sh_data, act_data;
  logic [DIGITS-1:0]      sh_en, sh_dp, sh_blink;
  logic [DIGITS-1:0]      act_en, act_dp, act_blink;

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FCNT_W-1:0]   fcnt;
  logic                blink_ph;

  logic             pending_c, accept_c;
  logic             pre_last_c, idx_last_c, fcnt_last_c, boundary_c;
  logic             lit_c;
  logic [3:0]       nib_c;
  logic             dp_c;
  logic [SEG_W-1:0] glyph_c;

  // load_ready is the registered inverse of the shadow-pending flag.
  assign pending_c   = !load_ready;
  assign accept_c    = load_valid && load_ready;
  assign pre_last_c  = (pre == PRE_W'(SCAN_DIV - 1));
  assign idx_last_c  = (idx == IDX_W'(DIGITS - 1));
  assign fcnt_last_c = (fcnt == FCNT_W'(BLINK_FRAMES - 1));
  assign boundary_c  = pre_last_c && idx_last_c;

  // Shadow/active double buffer; a commit wins over a same-cycle offer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_data    <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      sh_blink   <= '0;
      act_data   <= '0;
      act_en     <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
      load_ready <= 1'b1;
    end else if (boundary_c && pending_c) begin
      act_data   <= sh_data;
      act_en     <= sh_en;
      act_dp     <= sh_dp;
      act_blink  <= sh_blink;
      load_ready <= 1'b1;
    end else if (accept_c) begin
      sh_data    <= load_data;
      sh_en      <= load_en;
      sh_dp      <= load_dp;
      sh_blink   <= load_blink;
      load_ready <= 1'b0;
    end
  end

  // Scan prescaler, digit index, PWM phase and blink frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre      <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
      fcnt     <= '0;
      blink_ph <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pre_last_c) begin
        pre <= '0;
        idx <= idx_last_c ? '0 : idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
      if (boundary_c) begin
        fcnt <= fcnt_last_c ? '0 : fcnt + FCNT_W'(1);
        if (fcnt_last_c) blink_ph <= ~blink_ph;
      end
    end
  end

  always_comb begin
    nib_c = act_data[idx];
    dp_c  = act_dp[idx];
    lit_c = act_en[idx] && !(act_blink[idx] && blink_ph) && (pwm_cnt <= brightness);
  end

  seg_hex_decode u_hex (
    .nib   (nib_c),
    .dp    (dp_c),
    .seg_c (glyph_c)
  );

  // Registered pin drive; frame_start lines up with digit 0 appearing on cat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cat         <= {DIGITS{CAT_OFF}};
      seg         <= '0;
      frame_start <= 1'b0;
    end else begin
      cat         <= lit_c ? ~(DIGITS'(1) << idx) : {DIGITS{CAT_OFF}};
      seg         <= lit_c ? glyph_c : '0;
      frame_start <= (pre == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random
// loads, checked every cycle against a time-indexed behavioural model.
module tb_seg_scan_driver;

  localparam int unsigned DIGITS       = 8;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned PWM_BITS     = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = DIGITS * SCAN_DIV;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [7:0]  blink;
  } img_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic [31:0]         load_data = '0;
  logic [7:0]          load_en = '0;
  logic [7:0]          load_dp = '0;
  logic [7:0]          load_blink = '0;
  logic [PWM_BITS-1:0] brightness = '0;
  logic [7:0]          cat;
  logic [7:0]          seg;
  logic                frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_en(load_en), .load_dp(load_dp), .load_blink(load_blink),
    .brightness(brightness), .cat(cat), .seg(seg), .frame_start(frame_start)
  );

  int errors = 0;
  int checks = 0;

  // Model: t counts cycles since reset release; the image history is event based.
  int   t = 0;
  bit   chk_en = 1'b0;
  bit   prev_rst = 1'b0;
  bit   m_pending = 1'b0;
  bit   last_hs = 1'b0;
  img_t m_shadow = '0;
  img_t m_active = '0;
  img_t snap_active = '0;
  logic [PWM_BITS-1:0] snap_bright = '0;
  int   snap_t = 0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: check outputs, drive the model forward, advance the clock.
  task automatic cycle();
    logic [7:0] e_cat, e_seg;
    logic       e_fs, lit;
    int         s, idx, pwm, frame, ph;
    img_t       cur;
    if (chk_en) begin
      if (prev_rst) begin
        e_cat = 8'hFF; e_seg = 8'h00; e_fs = 1'b0;
      end else begin
        s     = snap_t;
        idx   = (s / SCAN_DIV) % DIGITS;
        pwm   = s % (1 << PWM_BITS);
        frame = s / FRAME;
        ph    = (frame / BLINK_FRAMES) % 2;
        lit   = snap_active.en[idx] && !(snap_active.blink[idx] && ph == 1) &&
                (pwm <= int'(snap_bright));
        e_cat = lit ? ~(8'(1) << idx) : 8'hFF;
        e_seg = lit ? {snap_active.dp[idx], glyph(snap_active.data[4*idx +: 4])} : 8'h00;
        e_fs  = (s % FRAME == 0);
      end
      check("cat", cat, e_cat);
      check("seg", seg, e_seg);
      check("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
      check("load_ready", {7'd0, load_ready}, {7'd0, !m_pending});
    end
    cur = '{data: load_data, en: load_en, dp: load_dp, blink: load_blink};
    last_hs = 1'b0;
    if (!rst_n) begin
      m_pending = 1'b0; m_active = '0; m_shadow = '0;
      prev_rst = 1'b1; t = 0; chk_en = 1'b1;
    end else begin
      snap_active = m_active; snap_bright = brightness; snap_t = t; prev_rst = 1'b0;
      last_hs = load_valid && !m_pending;
      if ((t % FRAME == FRAME - 1) && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end else if (last_hs) begin
        m_shadow = cur; m_pending = 1'b1;
      end
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offer an image and hold valid until the model says it was taken.
  task automatic offer(input img_t img);
    load_data = img.data; load_en = img.en; load_dp = img.dp; load_blink = img.blink;
    load_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle();
      if (last_hs) break;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    brightness = 2'd3;
    offer('{data: 32'h0123_4567, en: 8'hFF, dp: 8'h00, blink: 8'h00});
    run(3 * FRAME);

    // Second image held while the first is still pending.
    offer('{data: 32'h89AB_CDEF, en: 8'hF0, dp: 8'hA5, blink: 8'h00});
    offer('{data: 32'hFEDC_BA98, en: 8'h3C, dp: 8'h0F, blink: 8'h00});
    run(3 * FRAME);

    brightness = 2'd0;
    run(2 * FRAME);
    brightness = 2'd1;
    run(FRAME);

    brightness = 2'd3;
    offer('{data: 32'h0000_000D, en: 8'h01, dp: 8'h01, blink: 8'h01});
    run(9 * FRAME);

    for (int i = 0; i < 20 * FRAME; i++) begin
      load_valid = ($urandom_range(3) == 0);
      load_data  = $urandom;
      load_en    = 8'($urandom);
      load_dp    = 8'($urandom);
      load_blink = 8'($urandom);
      if ($urandom_range(15) == 0) brightness = PWM_BITS'($urandom);
      cycle();
    end
    load_valid = 1'b0;
    run(2 * FRAME);

    // Mid-frame reset with a pending image that must never show.
    brightness = 2'd3;
    offer('{data: 32'h8888_8888, en: 8'hFF, dp: 8'hFF, blink: 8'h00});
    run(3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(3 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
